// File: rtl/fetch_stage_pkg.sv
// Purpose: shared pipeline definitions for the IF stage. Holds the bubble
// encoding, the reset PC default, the fetch FSM state type and the
// {instr, pcplus4} payload handed to the IF/ID register.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Instruction plus its fall-through address, as seen by IF/ID
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcplus4;
  } fetch_pair_t;

endpackage

// File: rtl/fetch_stage.sv
// Purpose: IF stage. Owns the PC, issues one outstanding fetch at a time over
// a req/gnt/rvalid instruction port, applies decode-stage redirects, drops
// wrong-path responses and inserts NOP bubbles when nothing is available.
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   stall_f                 hazard unit: hold fetch outputs
//   pcsrc_d, pc_branch_d    decode redirect and its target
//   imem_req, imem_addr     fetch request and word-aligned address
//   imem_gnt                request accepted this cycle
//   imem_rvalid, imem_rdata fetch response
//   instr_f, pcplus4_f      registered pair presented to IF/ID
//   fetch_busy              a fetch is outstanding (state != IDLE)
module fetch_stage #(
  parameter logic [fetch_stage_pkg::XLEN-1:0] RESET_PC  = fetch_stage_pkg::RESET_PC,
  parameter logic [fetch_stage_pkg::XLEN-1:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall_f,
  input  logic                             pcsrc_d,
  input  logic [fetch_stage_pkg::XLEN-1:0] pc_branch_d,
  output logic                             imem_req,
  output logic [fetch_stage_pkg::XLEN-1:0] imem_addr,
  input  logic                             imem_gnt,
  input  logic                             imem_rvalid,
  input  logic [fetch_stage_pkg::XLEN-1:0] imem_rdata,
  output logic [fetch_stage_pkg::XLEN-1:0] instr_f,
  output logic [fetch_stage_pkg::XLEN-1:0] pcplus4_f,
  output logic                             fetch_busy
);
  import fetch_stage_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_req_q, pc_req_d;
  fetch_pair_t     out_q, out_d;
  fetch_pair_t     buf_q, buf_d;
  logic            buf_valid_q, buf_valid_d;
  fetch_pair_t     delivered;
  fetch_pair_t     bubble;
  logic            rsp_valid;

  // Next-state, next-PC, request and output-register selection
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_req_d    = pc_req_q;
    out_d       = out_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    imem_req    = 1'b0;

    delivered.instr   = imem_rdata;
    delivered.pcplus4 = pc_req_q + XLEN'(4);
    bubble.instr      = NOP_INSTR;
    bubble.pcplus4    = '0;
    rsp_valid         = (state_q == WAIT) && imem_rvalid;

    unique case (state_q)
      IDLE: begin
        // A pending redirect suppresses the request so no wrong-path fetch leaves
        imem_req = !buf_valid_q && !pcsrc_d;
        if (imem_req && imem_gnt) begin
          pc_req_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid)  state_d = IDLE;
        else if (pcsrc_d) state_d = DROP;
      end
      DROP: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Redirect always lands on a word boundary
    if (pcsrc_d) pc_d = pc_branch_d & ~XLEN'(3);

    // Output register, highest priority first
    if (pcsrc_d) begin
      out_d       = bubble;
      buf_valid_d = 1'b0;
    end else if (stall_f) begin
      // Hold outputs; park an arriving response so it is not lost
      if (rsp_valid) begin
        buf_d       = delivered;
        buf_valid_d = 1'b1;
      end
    end else if (buf_valid_q) begin
      out_d       = buf_q;
      buf_valid_d = 1'b0;
    end else if (rsp_valid) begin
      out_d = delivered;
    end else begin
      out_d = bubble;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pc_req_q      <= '0;
      out_q.instr   <= NOP_INSTR;
      out_q.pcplus4 <= '0;
      buf_q         <= '0;
      buf_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_req_q    <= pc_req_d;
      out_q       <= out_d;
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  assign imem_addr  = pc_q;
  assign instr_f    = out_q.instr;
  assign pcplus4_f  = out_q.pcplus4;
  assign fetch_busy = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: self-checking bench for fetch_stage. A cycle table drives every
// input and lists the outputs expected in that cycle; deliveries that IF/ID
// will capture are pushed to a scoreboard and popped when the DUT presents
// them with stall_f and pcsrc_d low. Reset-in-WAIT and a long grant
// withhold are written out by hand after the table.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f;
  logic        pcsrc_d;
  logic [31:0] pc_branch_d;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_f;
  logic [31:0] pcplus4_f;
  logic        fetch_busy;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall_f     (stall_f),
    .pcsrc_d     (pcsrc_d),
    .pc_branch_d (pc_branch_d),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_f     (instr_f),
    .pcplus4_f   (pcplus4_f),
    .fetch_busy  (fetch_busy)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        pcsrc;
    logic [31:0] tgt;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic [31:0] push_pc4;  // nonzero: push {rdata, push_pc4} to the scoreboard
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_busy;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t        tbl[$];
  fetch_pair_t sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          k       = 0;

  function automatic vec_t mk(input logic [31:0] rst, stall, pcsrc, tgt, gnt, rv, rdata,
                              push_pc4, e_req, e_addr, e_busy, e_instr, e_pc4);
    vec_t v;
    v.rst      = rst[0];
    v.stall    = stall[0];
    v.pcsrc    = pcsrc[0];
    v.tgt      = tgt;
    v.gnt      = gnt[0];
    v.rv       = rv[0];
    v.rdata    = rdata;
    v.push_pc4 = push_pc4;
    v.e_req    = e_req[0];
    v.e_addr   = e_addr;
    v.e_busy   = e_busy[0];
    v.e_instr  = e_instr;
    v.e_pc4    = e_pc4;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle at posedge+1, check at negedge, then let the edge happen
  task automatic step(input vec_t x);
    fetch_pair_t e;
    reset       = x.rst;
    stall_f     = x.stall;
    pcsrc_d     = x.pcsrc;
    pc_branch_d = x.tgt;
    imem_gnt    = x.gnt;
    imem_rvalid = x.rv;
    imem_rdata  = x.rdata;
    if (x.push_pc4 != 0) begin
      e.instr   = x.rdata;
      e.pcplus4 = x.push_pc4;
      sb.push_back(e);
    end
    @(negedge clk);
    chk("imem_req",   k, 32'(imem_req),   32'(x.e_req));
    chk("imem_addr",  k, imem_addr,       x.e_addr);
    chk("fetch_busy", k, 32'(fetch_busy), 32'(x.e_busy));
    chk("instr_f",    k, instr_f,         x.e_instr);
    chk("pcplus4_f",  k, pcplus4_f,       x.e_pc4);
    // IF/ID capture point
    if (!x.rst && !x.stall && !x.pcsrc && pcplus4_f != 0) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", k, pcplus4_f, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", k, instr_f,   e.instr);
        chk("sb_pc4",   k, pcplus4_f, e.pcplus4);
      end
    end
    @(posedge clk);
    #1;
    k++;
  endtask

  initial begin
    reset = 1'b1; stall_f = 1'b0; pcsrc_d = 1'b0; pc_branch_d = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;

    //            rst st ps tgt           g  rv rdata         push  req addr          bsy instr         pc4
    // Reset state, then gnt held high, one-cycle response, data = addr
    tbl.push_back(mk(0, 0, 0, 0,            1, 0, 0,            0,    1, 0,            0, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0,            1, 1, 0,            4,    0, 4,            1, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0,            1, 0, 0,            0,    1, 4,            0, 0,            4));
    tbl.push_back(mk(0, 0, 0, 0,            1, 1, 4,            8,    0, 8,            1, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0,            1, 0, 0,            0,    1, 8,            0, 4,            8));
    tbl.push_back(mk(0, 0, 0, 0,            1, 1, 8,            12,   0, 12,           1, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0,            1, 0, 0,            0,    1, 12,           0, 8,            12));
    // stall_f for 3 cycles while the response arrives: buffered, no request
    tbl.push_back(mk(0, 1, 0, 0,            1, 1, 12,           16,   0, 16,           1, 0,            0));
    tbl.push_back(mk(0, 1, 0, 0,            1, 0, 0,            0,    0, 16,           0, 0,            0));
    tbl.push_back(mk(0, 1, 0, 0,            1, 0, 0,            0,    0, 16,           0, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0,            1, 0, 0,            0,    0, 16,           0, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0,            1, 0, 0,            0,    1, 16,           0, 12,           16));
    // Redirect in WAIT before rvalid: old response dropped, refetch at 0x100
    tbl.push_back(mk(0, 0, 1, 32'h100,      1, 0, 0,            0,    0, 20,           1, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0,            1, 1, 16,           0,    0, 32'h100,      1, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0,            1, 0, 0,            0,    1, 32'h100,      0, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0,            1, 1, 32'h100,      0,    0, 32'h104,      1, 0,            0));
    // Redirect together with stall_f: flush to NOP, resume at target
    tbl.push_back(mk(0, 1, 1, 32'h200,      1, 0, 0,            0,    0, 32'h104,      0, 32'h100,      32'h104));
    tbl.push_back(mk(0, 1, 0, 0,            0, 0, 0,            0,    1, 32'h200,      0, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0,            1, 0, 0,            0,    1, 32'h200,      0, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0,            0, 1, 32'h200,      32'h204, 0, 32'h204,   1, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,            0,    1, 32'h204,      0, 32'h200,      32'h204));
    // Redirect coincident with rvalid, misaligned target
    tbl.push_back(mk(0, 0, 0, 0,            1, 0, 0,            0,    1, 32'h204,      0, 0,            0));
    tbl.push_back(mk(0, 0, 1, 32'h303,      0, 1, 32'h204,      0,    0, 32'h208,      1, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,            0,    1, 32'h300,      0, 0,            0));
    // PC wrap at the top of the address space
    tbl.push_back(mk(0, 0, 1, 32'hFFFF_FFFE, 1, 0, 0,           0,    0, 32'h300,      0, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0,            1, 0, 0,            0,    1, 32'hFFFF_FFFC, 0, 0,           0));
    tbl.push_back(mk(0, 0, 0, 0,            0, 1, 32'hFFFF_FFFC, 0,   0, 0,            1, 0,            0));
    // Redirects while dropping: target follows the latest one
    tbl.push_back(mk(0, 0, 0, 0,            1, 0, 0,            0,    1, 0,            0, 32'hFFFF_FFFC, 0));
    tbl.push_back(mk(0, 0, 1, 32'h40,       0, 0, 0,            0,    0, 4,            1, 0,            0));
    tbl.push_back(mk(0, 0, 1, 32'h50,       0, 0, 0,            0,    0, 32'h40,       1, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0,            0, 1, 0,            0,    0, 32'h50,       1, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0, 0,            0,    1, 32'h50,       0, 0,            0));

    foreach (tbl[i]) step(tbl[i]);

    // gnt withheld 5 cycles: request and address stable, not busy, bubbles
    for (int i = 0; i < 5; i++)
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h50, 0, 0, 0));

    // Reset while in WAIT with a held (stalled) instruction on the outputs
    step(mk(0, 0, 0, 0, 1, 0, 0,        0, 1, 32'h50, 0, 0,        0));
    step(mk(0, 0, 0, 0, 0, 1, 32'h1234, 0, 0, 32'h54, 1, 0,        0));
    step(mk(0, 1, 0, 0, 1, 0, 0,        0, 1, 32'h54, 0, 32'h1234, 32'h54));
    step(mk(1, 1, 0, 0, 0, 0, 0,        0, 0, 32'h58, 1, 32'h1234, 32'h54));
    step(mk(0, 0, 0, 0, 1, 0, 0,        0, 1, 0,      0, 0,        0));
    step(mk(0, 0, 0, 0, 0, 1, 32'hABCD, 4, 0, 4,      1, 0,        0));
    step(mk(0, 0, 0, 0, 0, 0, 0,        0, 1, 4,      0, 32'hABCD, 4));

    chk("sb_drain", k, 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
